// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, frame size and bit-period helper.
package uart_pkg;

  localparam int unsigned UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    BIdle,
    BStart,
    BData,
    BStop
  } byte_state_e;

  typedef enum logic [1:0] {
    WIdle,
    WLo,
    WHi
  } word_state_e;

  // Integer-truncated clocks per bit.
  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                    input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte transmitter. tx is registered, so the line lags the FSM state by one
// cycle; busy_o covers that lag so callers see the line as busy until the stop
// bit has fully left the pin.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 52
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  byte_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d;
  logic          active_q;
  logic          tick;

  assign tick   = (cnt_q == CntW'(CLKS_PER_BIT - 1));
  assign tx_o   = tx_q;
  assign busy_o = (state_q != BIdle) || active_q;

  // Next-state, bit timer and line value; done fires on the last stop-bit cycle
  // so a back-to-back start continues without an idle bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    tx_d    = 1'b1;
    done_o  = 1'b0;
    if (state_q != BIdle) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
    unique case (state_q)
      BIdle: begin
        cnt_d = '0;
        if (start_i) begin
          data_d  = data_i;
          state_d = BStart;
        end
      end
      BStart: begin
        tx_d = 1'b0;
        if (tick) begin
          idx_d   = '0;
          state_d = BData;
        end
      end
      BData: begin
        tx_d = data_q[idx_q];
        if (tick) begin
          if (idx_q == 3'd7) state_d = BStop;
          else               idx_d   = idx_q + 1'b1;
        end
      end
      BStop: begin
        if (tick) begin
          done_o = 1'b1;
          if (start_i) begin
            data_d  = data_i;
            state_d = BStart;
          end else begin
            state_d = BIdle;
          end
        end
      end
      default: state_d = BIdle;
    endcase
  end

  // State registers; reset abandons any frame and returns the line high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= BIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      tx_q     <= 1'b1;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      tx_q     <= tx_d;
      active_q <= (state_q != BIdle);
    end
  end

endmodule

// File: rtl/uart_sample_tx.sv
// Buffers 16-bit samples in a small FIFO and sends each as two 8N1 bytes,
// low byte first, with no gap between consecutive words.
module uart_sample_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 12_000_000,
  parameter int unsigned BAUD       = 230_400,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          CLK_IN,
  input  logic                          RST_IN,
  input  logic [15:0]                   SAMPLE_i,
  input  logic                          SAMPLE_VALID_i,
  output logic                          SAMPLE_READY_o,
  output logic                          UART_TX_o,
  output logic                          BUSY_o,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL_o
);

  localparam int unsigned ClksPerBit = calc_clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned AddrW      = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW       = AddrW + 1;

  logic [15:0]     mem_q [FIFO_DEPTH];
  logic [AddrW:0]  wr_ptr_q, rd_ptr_q, level;
  logic            full, empty, push, pop;
  logic [15:0]     rd_word;

  word_state_e     wstate_q, wstate_d;
  logic [15:0]     word_q, word_d;
  logic            byte_start, byte_done, byte_busy;
  logic [7:0]      byte_data;

  assign level          = wr_ptr_q - rd_ptr_q;
  assign full           = (level == LvlW'(FIFO_DEPTH));
  assign empty          = (level == '0);
  // No pop bypass: a full FIFO refuses the push even in a pop cycle.
  assign SAMPLE_READY_o = !full && !RST_IN;
  assign push           = SAMPLE_VALID_i && SAMPLE_READY_o;
  assign rd_word        = mem_q[rd_ptr_q[AddrW-1:0]];
  assign FIFO_LEVEL_o   = level;
  assign BUSY_o         = !empty || (wstate_q != WIdle) || byte_busy;

  // FIFO storage, written only on an accepted push.
  always_ff @(posedge CLK_IN) begin
    if (push) mem_q[wr_ptr_q[AddrW-1:0]] <= SAMPLE_i;
  end

  // FIFO pointers with an extra wrap bit for full/empty.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Word sequencing; the high-byte done cycle pops the next word directly.
  always_comb begin
    wstate_d   = wstate_q;
    word_d     = word_q;
    pop        = 1'b0;
    byte_start = 1'b0;
    byte_data  = word_q[7:0];
    unique case (wstate_q)
      WIdle: begin
        if (!empty) begin
          pop        = 1'b1;
          word_d     = rd_word;
          byte_start = 1'b1;
          byte_data  = rd_word[7:0];
          wstate_d   = WLo;
        end
      end
      WLo: begin
        if (byte_done) begin
          byte_start = 1'b1;
          byte_data  = word_q[15:8];
          wstate_d   = WHi;
        end
      end
      WHi: begin
        if (byte_done) begin
          if (!empty) begin
            pop        = 1'b1;
            word_d     = rd_word;
            byte_start = 1'b1;
            byte_data  = rd_word[7:0];
            wstate_d   = WLo;
          end else begin
            wstate_d = WIdle;
          end
        end
      end
      default: wstate_d = WIdle;
    endcase
  end

  // Word FSM state and latched sample.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      wstate_q <= WIdle;
      word_q   <= '0;
    end else begin
      wstate_q <= wstate_d;
      word_q   <= word_d;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(ClksPerBit)
  ) u_byte_tx (
    .clk_i  (CLK_IN),
    .rst_i  (RST_IN),
    .start_i(byte_start),
    .data_i (byte_data),
    .tx_o   (UART_TX_o),
    .busy_o (byte_busy),
    .done_o (byte_done)
  );

endmodule

// File: tb/tb_uart_sample_tx.sv
// Directed bench for uart_sample_tx: default-rate DUT plus a 115200-baud copy.
module tb_uart_sample_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sample = '0;
  logic        valid = 1'b0;
  wire         ready, tx, busy;
  wire  [2:0]  level;

  logic [15:0] sample_s = '0;
  logic        valid_s = 1'b0;
  wire         ready_s, tx_s, busy_s;
  wire  [2:0]  level_s;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  logic [15:0] burst_w [6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_sample_tx dut (
    .CLK_IN        (clk),
    .RST_IN        (rst),
    .SAMPLE_i      (sample),
    .SAMPLE_VALID_i(valid),
    .SAMPLE_READY_o(ready),
    .UART_TX_o     (tx),
    .BUSY_o        (busy),
    .FIFO_LEVEL_o  (level)
  );

  uart_sample_tx #(
    .CLK_FREQ  (12_000_000),
    .BAUD      (115_200),
    .FIFO_DEPTH(4)
  ) dut_slow (
    .CLK_IN        (clk),
    .RST_IN        (rst),
    .SAMPLE_i      (sample_s),
    .SAMPLE_VALID_i(valid_s),
    .SAMPLE_READY_o(ready_s),
    .UART_TX_o     (tx_s),
    .BUSY_o        (busy_s),
    .FIFO_LEVEL_o  (level_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    if (cyc > t) begin
      total++;
      bad++;
      $display("FAIL schedule: cycle=%0d already past %0d", cyc, t);
    end
    while (cyc < t) tick();
  endtask

  // Push one word; returns with valid still high when hold is set.
  task automatic push(input logic [15:0] w, input bit hold);
    int n;
    n = 0;
    sample = w;
    valid  = 1'b1;
    while (!ready && n < 3000) begin
      tick();
      n++;
    end
    if (!ready) begin
      total++;
      bad++;
      $display("FAIL push_ready_timeout: ready=%b required 1", ready);
    end
    tick();
    if (!hold) valid = 1'b0;
  endtask

  // Line check of one word whose start bit first appears after edge f.
  task automatic check_word(input logic [15:0] w, input int f, input string name);
    logic        exp_bit;
    logic [15:0] dec;
    int          off;
    dec = '0;
    for (int k = 0; k < 20; k++) begin
      if (k == 0 || k == 10)      exp_bit = 1'b0;
      else if (k == 9 || k == 19) exp_bit = 1'b1;
      else if (k < 9)             exp_bit = w[k-1];
      else                        exp_bit = w[k-3];
      for (int o = 0; o < 3; o++) begin
        off = (o == 0) ? 0 : ((o == 1) ? 26 : 51);
        wait_until(f + 52 * k + off);
        total++;
        if (tx !== exp_bit) begin
          bad++;
          $display("FAIL %s bit%0d+%0d: tx=%b required %b", name, k, off, tx, exp_bit);
        end
        if (o == 1 && k >= 1 && k <= 8)   dec[k-1] = tx;
        if (o == 1 && k >= 11 && k <= 18) dec[k-3] = tx;
      end
    end
    total++;
    if (dec !== w) begin
      bad++;
      $display("FAIL %s decode: got %h required %h", name, dec, w);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (tx !== 1'b1)    begin bad++; $display("FAIL rst_tx: %b vs 1", tx); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL rst_ready: %b vs 0", ready); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL rst_busy: %b vs 0", busy); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL rst_level: %0d vs 0", level); end
    rst = 1'b0;
    tick();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rel_ready: %b vs 1", ready); end
    total++; if (tx !== 1'b1)    begin bad++; $display("FAIL rel_tx: %b vs 1", tx); end
  endtask

  task automatic test_single_word();
    int n;
    push(16'h4000, 1'b0);
    n = cyc;
    total++; if (level !== 3'd1) begin bad++; $display("FAIL single_level: %0d vs 1", level); end
    total++; if (busy !== 1'b1)  begin bad++; $display("FAIL single_busy_rise: %b vs 1", busy); end
    tick();
    total++; if (tx !== 1'b1)    begin bad++; $display("FAIL single_fall_early: %b vs 1", tx); end
    check_word(16'h4000, n + 2, "single");
    wait_until(n + 2 + 1039);
    total++; if (busy !== 1'b1)  begin bad++; $display("FAIL single_busy_hold: %b vs 1", busy); end
    tick();
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL single_busy_fall: %b vs 0", busy); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL single_level_end: %0d vs 0", level); end
  endtask

  task automatic test_bit_alignment();
    int n;
    push(16'h55AA, 1'b0);
    n = cyc;
    check_word(16'h55AA, n + 2, "align");
    wait_until(n + 2 + 1040);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL align_busy: %b vs 0", busy); end
  endtask

  // Also covers the full-FIFO pop cycle: the held push must wait one cycle.
  task automatic test_burst();
    int f0;
    burst_w[0] = 16'h4000; burst_w[1] = 16'h6100; burst_w[2] = 16'h9003;
    burst_w[3] = 16'h0029; burst_w[4] = 16'h4009; burst_w[5] = 16'h9119;
    f0 = cyc + 3;
    fork
      begin
        for (int i = 0; i < 5; i++) push(burst_w[i], 1'b1);
        sample = burst_w[5];
        total++; if (level !== 3'd4) begin bad++; $display("FAIL burst_full_level: %0d vs 4", level); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL burst_ready_drop: %b vs 0", ready); end
      end
      check_word(burst_w[0], f0, "burst0");
    join
    total++; if (level !== 3'd3) begin bad++; $display("FAIL full_pop_level: %0d vs 3", level); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL full_pop_ready: %b vs 1", ready); end
    tick();
    valid = 1'b0;
    total++; if (level !== 3'd4) begin bad++; $display("FAIL full_pop_accept: %0d vs 4", level); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL full_pop_ready2: %b vs 0", ready); end
    for (int i = 1; i < 6; i++) check_word(burst_w[i], f0 + 1040 * i, $sformatf("burst%0d", i));
    wait_until(f0 + 6 * 1040);
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL burst_busy_end: %b vs 0", busy); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL burst_level_end: %0d vs 0", level); end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    push(16'h9119, 1'b0);
    n = cyc;
    push(16'h4009, 1'b0);
    wait_until(n + 2 + 14 * 52 + 26);
    total++; if (tx !== 1'b0)    begin bad++; $display("FAIL mid_tx_before: %b vs 0", tx); end
    total++; if (level !== 3'd1) begin bad++; $display("FAIL mid_level_before: %0d vs 1", level); end
    rst = 1'b1;
    tick();
    total++; if (tx !== 1'b1)    begin bad++; $display("FAIL mid_rst_tx: %b vs 1", tx); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL mid_rst_level: %0d vs 0", level); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL mid_rst_busy: %b vs 0", busy); end
    rst = 1'b0;
    for (int i = 0; i < 60; i++) tick();
    total++; if (tx !== 1'b1)    begin bad++; $display("FAIL mid_no_resume_tx: %b vs 1", tx); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL mid_no_resume_busy: %b vs 0", busy); end
    push(16'h0029, 1'b0);
    n = cyc;
    check_word(16'h0029, n + 2, "after_rst");
    wait_until(n + 2 + 1040);
  endtask

  task automatic test_param_sweep();
    int f;
    sample_s = 16'h0001;
    valid_s  = 1'b1;
    tick();
    valid_s  = 1'b0;
    f = cyc + 2;
    wait_until(f - 1);
    total++; if (tx_s !== 1'b1) begin bad++; $display("FAIL slow_pre: %b vs 1", tx_s); end
    wait_until(f);
    total++; if (tx_s !== 1'b0) begin bad++; $display("FAIL slow_start: %b vs 0", tx_s); end
    wait_until(f + 52);
    total++; if (tx_s !== 1'b0) begin bad++; $display("FAIL slow_start52: %b vs 0", tx_s); end
    wait_until(f + 103);
    total++; if (tx_s !== 1'b0) begin bad++; $display("FAIL slow_start_end: %b vs 0", tx_s); end
    wait_until(f + 104);
    total++; if (tx_s !== 1'b1) begin bad++; $display("FAIL slow_bit0: %b vs 1", tx_s); end
    wait_until(f + 207);
    total++; if (tx_s !== 1'b1) begin bad++; $display("FAIL slow_bit0_end: %b vs 1", tx_s); end
    wait_until(f + 208);
    total++; if (tx_s !== 1'b0) begin bad++; $display("FAIL slow_bit1: %b vs 0", tx_s); end
    wait_until(f + 2079);
    total++; if (busy_s !== 1'b1) begin bad++; $display("FAIL slow_busy_hold: %b vs 1", busy_s); end
    wait_until(f + 2080);
    total++; if (busy_s !== 1'b0) begin bad++; $display("FAIL slow_busy_fall: %b vs 0", busy_s); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_bit_alignment();
    test_burst();
    test_reset_mid_frame();
    test_param_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
